tile_scheduler: RTL
===================

Name: tile_scheduler

Overview:
- Frame-level sequencer for the tile rasterizer.
- Walks the screen in raster-order tiles and issues each tile's pixel offset and ping-pong buffer ID to the rasterizer.
- Overlaps rasterizing tile N into one colour buffer with writeback of tile N-1 from the other buffer.
- Sits between the frame/VGA control logic and the rasterizer / framebuffer writer.

Parameters:
- SCREEN_W, 640, screen width in pixels; multiple of TILE_DIM.
- SCREEN_H, 480, screen height in pixels; multiple of TILE_DIM.
- TILE_DIM, 8, tile edge in pixels; must match the rasterizer's tileDim.

Ports:
- BOARD_CLK  in  1  sole clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- frameStart  in  1  one-cycle request to render a frame; honoured only in IDLE
- frameDone  out  1  one-cycle pulse when the last tile's writeback completes
- busy  out  1  high in any state other than IDLE
- startRasterizing  out  1  four-phase request to rasterizer
- doneRasterizing  in  1  four-phase acknowledge from rasterizer
- rasterTileID  out  1  colour buffer the rasterizer writes (0/1)
- rasterxOffset, rasteryOffset  out  10 each  pixel origin of the current tile
- wbStart  out  1  four-phase request to framebuffer writer
- wbDone  in  1  four-phase acknowledge from writer
- wbTileID  out  1  buffer to read back
- wbxOffset, wbyOffset  out  10 each  pixel origin of the tile being written back
- frameCycles, stallCycles  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset values: all outputs 0. Raster FSM = IDLE, writeback channel = WB_IDLE, tile counters 0, buffer select 0.
- RESET mid-frame abandons all work. Requests drop the next cycle; no frameDone is issued.
- Four-phase handshake on both channels:
  - raise req; hold until ack=1; drop req; wait for ack=0 before the next req.
  - Offsets and IDs are stable from req rise until ack falls.
- Raster FSM states:
  - IDLE: on frameStart, load tile (0,0) and buffer 0 → R_REQ. Latency: startRasterizing is high the cycle after frameStart.
  - R_REQ: startRasterizing=1. On doneRasterizing=1 → R_ACK.
  - R_ACK: startRasterizing=0. On doneRasterizing=0 → HANDOFF.
  - HANDOFF:
    - If the writeback channel is in WB_IDLE: launch writeback with the current buffer ID and offsets, in the same cycle.
    - Then, if this was the last tile → FLUSH. Otherwise toggle buffer select, advance the tile, → R_REQ.
    - If the writeback channel is busy: stay in HANDOFF (stall).
  - FLUSH: wait for WB_IDLE, then pulse frameDone for one cycle → IDLE.
- Tile advance:
  - xTile increments; when it wraps from SCREEN_W/TILE_DIM-1 to 0, yTile increments.
  - Last tile is (SCREEN_W/TILE_DIM-1, SCREEN_H/TILE_DIM-1).
  - Offset = tile index × TILE_DIM, truncated to 10 bits. Parameters are restricted to ≤1023 pixels.
- Buffer invariant: the rasterizer and the writer never hold the same buffer ID concurrently.
- Simultaneous events:
  - frameStart outside IDLE is ignored.
  - frameStart in the same cycle as the frameDone pulse is ignored (FSM is still in FLUSH).
  - Writeback reaching WB_IDLE in the same cycle HANDOFF samples it counts as busy; the launch happens next cycle.
- Single-tile screen: HANDOFF goes straight to FLUSH. frameDone follows that tile's writeback.

Optional Feature:
- Macro: TILE_SCHED_PERF_EN.
- Defined:
  - frameCycles counts cycles with busy=1. It clears on an accepted frameStart and holds after frameDone.
  - stallCycles counts cycles spent in HANDOFF waiting on writeback. It clears likewise.
  - Counters saturate at 32'hFFFFFFFF.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Package tile_sched_pkg:
  - raster FSM enum (IDLE, R_REQ, R_ACK, HANDOFF, FLUSH);
  - channel enum (WB_IDLE, WB_REQ, WB_ACK);
  - function tile_offset(index, TILE_DIM).
- Sub-module fourphase_req:
  - generic request side of the four-phase handshake, with launch/idle interface;
  - latches the payload (ID + offsets) at launch;
  - one instance for the writeback channel.
- Raster channel logic stays inline.

Test Plan (SCREEN_W=16, SCREEN_H=16, TILE_DIM=8 → 4 tiles unless noted):
- Reset, then frameStart; rasterizer model acks after 5 cycles → first request at cycle 1 with offsets (0,0), ID 0. Tiles then issue (8,0)/ID1, (0,8)/ID0, (8,8)/ID1. One frameDone after the 4th writeback.
- Writer model takes 40 cycles, rasterizer 5 → HANDOFF stalls every tile after the first. wbTileID never equals rasterTileID while both requests are active. With PERF_EN, stallCycles > 0 and reproduces exactly from the model.
- frameStart pulsed mid-frame and in the frameDone cycle → ignored. Exactly 4 raster requests, 1 frameDone.
- RESET asserted while in R_REQ with wbStart high → next cycle all outputs 0. A subsequent frameStart restarts at (0,0)/ID0.
- SCREEN_W=8, SCREEN_H=8 → single tile, ID 0. frameDone follows that tile's writeback completion; no buffer toggle observed.
- Default 640×480 → exactly 4800 raster requests. Last offsets (632,472). frameCycles matches the bench cycle count (PERF_EN defined); 0 when undefined.

Source files
------------

// File: rtl/tile_sched_pkg.sv
// Shared types and helpers for the tile scheduler: FSM encodings and tile offset math.
package tile_sched_pkg;

  typedef enum logic [2:0] {IDLE, R_REQ, R_ACK, HANDOFF, FLUSH} raster_state_e;
  typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_ACK} wb_state_e;

  localparam int OFFSET_W  = 10;
  localparam int PAYLOAD_W = 1 + 2 * OFFSET_W;

  // Pixel origin of a tile; screens are limited to 1023 pixels, so truncation is lossless.
  function automatic logic [OFFSET_W-1:0] tile_offset(input logic [31:0] index,
                                                       input logic [31:0] tile_dim);
    logic [31:0] w_prod;
    w_prod = index * tile_dim;
    return w_prod[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/fourphase_req.sv
// Request side of a four-phase handshake; payload is captured at launch and held until
// the channel returns to idle.
module fourphase_req
  import tile_sched_pkg::*;
#(
  parameter int WIDTH = 21
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_launch,
  input  logic [WIDTH-1:0] i_payload,
  input  logic             i_ack,
  output logic             o_idle,
  output logic             o_req,
  output logic [WIDTH-1:0] o_payload
);

  // state   | meaning
  // WB_IDLE | free; accepts a launch
  // WB_REQ  | req high, waiting for ack=1
  // WB_ACK  | req low, waiting for ack=0

  wb_state_e        r_state, w_next;
  logic [WIDTH-1:0] r_payload;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= WB_IDLE;
      r_payload <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == WB_IDLE && i_launch) r_payload <= i_payload;
    end
  end

  always_comb begin
    w_next = r_state;
    o_idle = 1'b0;
    o_req  = 1'b0;
    case (r_state)
      WB_IDLE: begin
        o_idle = 1'b1;
        if (i_launch) w_next = WB_REQ;
      end
      WB_REQ: begin
        o_req = 1'b1;
        if (i_ack) w_next = WB_ACK;
      end
      WB_ACK:  if (!i_ack) w_next = WB_IDLE;
      default: w_next = WB_IDLE;
    endcase
  end

  assign o_payload = r_payload;

endmodule

// File: rtl/tile_scheduler.sv
// Frame sequencer: rasterizes tiles in raster order, overlapping writeback of the previous
// tile from the other ping-pong buffer. Perf counters exist only with TILE_SCHED_PERF_EN.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int TILE_DIM = 8
) (
  input  logic        BOARD_CLK,
  input  logic        RESET,
  input  logic        frameStart,
  output logic        frameDone,
  output logic        busy,
  output logic        startRasterizing,
  input  logic        doneRasterizing,
  output logic        rasterTileID,
  output logic [9:0]  rasterxOffset,
  output logic [9:0]  rasteryOffset,
  output logic        wbStart,
  input  logic        wbDone,
  output logic        wbTileID,
  output logic [9:0]  wbxOffset,
  output logic [9:0]  wbyOffset,
  output logic [31:0] frameCycles,
  output logic [31:0] stallCycles
);

  // state   | meaning
  // IDLE    | waiting for frameStart
  // R_REQ   | startRasterizing high, waiting for ack
  // R_ACK   | request dropped, waiting for ack to fall
  // HANDOFF | hand finished tile to writeback (stalls while writer busy)
  // FLUSH   | last tile handed off, waiting for its writeback

  localparam int TILES_X = SCREEN_W / TILE_DIM;
  localparam int TILES_Y = SCREEN_H / TILE_DIM;
  localparam int XW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int YW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
  localparam logic [XW-1:0] LAST_X = XW'(TILES_X - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(TILES_Y - 1);

  raster_state_e        r_state, w_next;
  logic [XW-1:0]        r_x_tile;
  logic [YW-1:0]        r_y_tile;
  logic                 r_buf;
  logic                 w_wb_idle, w_launch, w_advance, w_accept, w_last_tile;
  logic [PAYLOAD_W-1:0] w_wb_payload;

  assign w_last_tile = (r_x_tile == LAST_X) && (r_y_tile == LAST_Y);

  always_ff @(posedge BOARD_CLK) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_x_tile <= '0;
      r_y_tile <= '0;
      r_buf    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_x_tile <= '0;
        r_y_tile <= '0;
        r_buf    <= 1'b0;
      end else if (w_advance) begin
        r_buf <= ~r_buf;
        if (r_x_tile == LAST_X) begin
          r_x_tile <= '0;
          r_y_tile <= r_y_tile + YW'(1);
        end else begin
          r_x_tile <= r_x_tile + XW'(1);
        end
      end
    end
  end

  always_comb begin
    w_next           = r_state;
    w_accept         = 1'b0;
    w_launch         = 1'b0;
    w_advance        = 1'b0;
    frameDone        = 1'b0;
    startRasterizing = 1'b0;
    case (r_state)
      IDLE: begin
        if (frameStart) begin
          w_accept = 1'b1;
          w_next   = R_REQ;
        end
      end
      R_REQ: begin
        startRasterizing = 1'b1;
        if (doneRasterizing) w_next = R_ACK;
      end
      R_ACK: if (!doneRasterizing) w_next = HANDOFF;
      HANDOFF: begin
        // Writer is sampled from its registered state, so a writer finishing this cycle
        // is still busy here and the launch slips one cycle.
        if (w_wb_idle) begin
          w_launch = 1'b1;
          if (w_last_tile) begin
            w_next = FLUSH;
          end else begin
            w_advance = 1'b1;
            w_next    = R_REQ;
          end
        end
      end
      FLUSH: begin
        if (w_wb_idle) begin
          frameDone = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy          = (r_state != IDLE);
  assign rasterTileID  = r_buf;
  assign rasterxOffset = tile_offset(32'(r_x_tile), 32'(TILE_DIM));
  assign rasteryOffset = tile_offset(32'(r_y_tile), 32'(TILE_DIM));

  fourphase_req #(.WIDTH(PAYLOAD_W)) u_wb_req (
    .i_clk     (BOARD_CLK),
    .i_rst     (RESET),
    .i_launch  (w_launch),
    .i_payload ({rasterTileID, rasterxOffset, rasteryOffset}),
    .i_ack     (wbDone),
    .o_idle    (w_wb_idle),
    .o_req     (wbStart),
    .o_payload (w_wb_payload)
  );

  assign {wbTileID, wbxOffset, wbyOffset} = w_wb_payload;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] r_frame_cycles, r_stall_cycles;

  always_ff @(posedge BOARD_CLK) begin
    if (RESET || w_accept) begin
      r_frame_cycles <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (busy && (r_frame_cycles != '1)) r_frame_cycles <= r_frame_cycles + 32'd1;
      if ((r_state == HANDOFF) && !w_wb_idle && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign frameCycles = r_frame_cycles;
  assign stallCycles = r_stall_cycles;
`else
  assign frameCycles = '0;
  assign stallCycles = '0;
`endif

endmodule
